hdlc_rx_bitproc: RTL and testbench

Bit-level front end of the HDLC receive path: samples the serial Rx line, detects flags and aborts, removes stuffed zeros and assembles LSB-first bytes. Its byte/flag/frame strobes feed the Rx byte controller that fills the Rx data buffer and computes FCS. Frame-level bookkeeping (FCS, buffer, CPU access) is out of scope.

---
 rtl/hdlc_rx_bitproc.sv | 269 ++++++++++++++++++++++++++
 tb/tb_hdlc_rx_bitproc.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_bitproc.sv
`default_nettype none
//==============================================================================
// Module   : hdlc_rx_bitproc
// Purpose  : Bit-level front end of the HDLC receive path. Consumes one serial
//            bit per enabled clock, recognises flags (0111_1110) and aborts
//            (seven consecutive ones), drops stuffed zeros and assembles
//            LSB-first bytes for the downstream Rx byte controller.
//
// Ports    : Clk            in   system clock, all state on rising edge
//            Rst            in   asynchronous active-high reset
//            Rx             in   serial receive bit, sampled when RxEN=1
//            RxEN           in   bit enable, one bit consumed per enabled clock
//            Rx_FlagDetect  out  one-cycle pulse per flag
//            Rx_AbortDetect out  one-cycle pulse on abort outside HUNT
//            Rx_NewByte     out  one-cycle pulse, Rx_Data holds a new byte
//            Rx_Data        out  last assembled byte (bit 0 = first received)
//            Rx_ValidFrame  out  level, high while a frame has data in progress
//            Rx_EoF         out  one-cycle pulse on closing flag of a data frame
//            Rx_FrameError  out  pulse with Rx_EoF when frame is not byte-aligned
//            Rx_Overflow    out  level, frame exceeded MAX_BYTES
//
// Config   : HDLC_RX_ABORT_EN - when defined, seven consecutive ones abort the
//            frame. When undefined, runs of ones are ordinary data and
//            Rx_AbortDetect stays low.
//
// Revision : 1.0 - initial release
//==============================================================================
module hdlc_rx_bitproc #(
    parameter int MAX_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_ValidFrame,
    output logic       Rx_EoF,
    output logic       Rx_FrameError,
    output logic       Rx_Overflow
);

`ifdef HDLC_RX_ABORT_EN
    localparam bit c_ABORT_EN = 1'b1;
`else
    localparam bit c_ABORT_EN = 1'b0;
`endif

    // The delay line is as long as a flag minus its closing zero, so when the
    // closing zero arrives the whole flag prefix is still inside the line and
    // can be thrown away without ever reaching the byte assembler.
    localparam int c_LINE_LEN   = 7;
    localparam int c_BYTE_CNT_W = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,   // searching for a flag, nothing is delivered
        S_FLAG = 2'd1,   // flag seen, no data bit delivered yet
        S_DATA = 2'd2    // at least one data bit of this frame delivered
    } state_t;

    //--------------------------------------------------------------------------
    // Registered state
    //--------------------------------------------------------------------------
    state_t                    r_state;
    logic [2:0]                r_ones;
    logic [c_LINE_LEN-1:0]     r_lineBits;
    logic [c_LINE_LEN-1:0]     r_lineValid;
    logic [6:0]                r_shift;
    logic [2:0]                r_bitCnt;
    logic [c_BYTE_CNT_W-1:0]   r_byteCnt;

    logic                      r_flagDetect;
    logic                      r_abortDetect;
    logic                      r_newByte;
    logic [7:0]                r_data;
    logic                      r_validFrame;
    logic                      r_eof;
    logic                      r_frameError;
    logic                      r_overflow;

    //--------------------------------------------------------------------------
    // Next-state values
    //--------------------------------------------------------------------------
    state_t                    w_stateNext;
    logic [2:0]                w_onesNext;
    logic [c_LINE_LEN-1:0]     w_lineBitsNext;
    logic [c_LINE_LEN-1:0]     w_lineValidNext;
    logic [6:0]                w_shiftNext;
    logic [2:0]                w_bitCntNext;
    logic [c_BYTE_CNT_W-1:0]   w_byteCntNext;

    logic                      w_flagDetectNext;
    logic                      w_abortDetectNext;
    logic                      w_newByteNext;
    logic [7:0]                w_dataNext;
    logic                      w_validFrameNext;
    logic                      w_eofNext;
    logic                      w_frameErrorNext;
    logic                      w_overflowNext;

    // Classification of the sampled bit
    logic                      w_isFlag;
    logic                      w_isAbort;
    logic                      w_insert;
    logic                      w_exitValid;
    logic                      w_exitBit;

    //--------------------------------------------------------------------------
    // Next-state and output logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_stateNext       = r_state;
        w_onesNext        = r_ones;
        w_lineBitsNext    = r_lineBits;
        w_lineValidNext   = r_lineValid;
        w_shiftNext       = r_shift;
        w_bitCntNext      = r_bitCnt;
        w_byteCntNext     = r_byteCnt;

        w_flagDetectNext  = 1'b0;
        w_abortDetectNext = 1'b0;
        w_newByteNext     = 1'b0;
        w_dataNext        = r_data;
        w_validFrameNext  = r_validFrame;
        w_eofNext         = 1'b0;
        w_frameErrorNext  = 1'b0;
        w_overflowNext    = r_overflow;

        w_isFlag          = 1'b0;
        w_isAbort         = 1'b0;
        w_insert          = 1'b0;
        w_exitValid       = 1'b0;
        w_exitBit         = 1'b0;

        if (RxEN) begin
            //------------------------------------------------------------------
            // Classify the sampled bit against the run of preceding ones.
            //------------------------------------------------------------------
            if (Rx) begin
                w_onesNext = (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;
                // The seventh one in a row is an abort; a saturated counter
                // (already 7) does not re-trigger on longer runs.
                if (c_ABORT_EN && (r_ones == 3'd6)) begin
                    w_isAbort = 1'b1;
                end else begin
                    w_insert = 1'b1;
                end
            end else begin
                w_onesNext = 3'd0;
                if (r_ones == 3'd6) begin
                    w_isFlag = 1'b1;
                end else if (r_ones != 3'd5) begin
                    // A zero after exactly five ones is a stuffed bit and is
                    // simply dropped; every other zero is data.
                    w_insert = 1'b1;
                end
            end

            //------------------------------------------------------------------
            // Act on the classification.
            //------------------------------------------------------------------
            if (w_isFlag) begin
                w_flagDetectNext = 1'b1;
                w_lineValidNext  = '0;
                w_bitCntNext     = 3'd0;
                w_byteCntNext    = '0;
                w_overflowNext   = 1'b0;
                w_validFrameNext = 1'b0;
                w_stateNext      = S_FLAG;
                // Back-to-back flags in S_FLAG are idle fill, not empty frames.
                if (r_state == S_DATA) begin
                    w_eofNext        = 1'b1;
                    w_frameErrorNext = (r_bitCnt != 3'd0);
                end
            end else if (w_isAbort) begin
                // The line content (including the bit that would have exited
                // now) belongs to the aborted frame and is discarded.
                w_abortDetectNext = (r_state != S_HUNT);
                w_lineValidNext   = '0;
                w_bitCntNext      = 3'd0;
                w_byteCntNext     = '0;
                w_overflowNext    = 1'b0;
                w_validFrameNext  = 1'b0;
                w_stateNext       = S_HUNT;
            end else if (w_insert) begin
                // Oldest entry lives in the top stage of the line.
                w_lineBitsNext  = {r_lineBits[c_LINE_LEN-2:0], Rx};
                w_lineValidNext = {r_lineValid[c_LINE_LEN-2:0], 1'b1};
                w_exitValid     = r_lineValid[c_LINE_LEN-1];
                w_exitBit       = r_lineBits[c_LINE_LEN-1];

                // Bits leaving the line while hunting are never delivered.
                if (w_exitValid && (r_state != S_HUNT)) begin
                    w_stateNext      = S_DATA;
                    w_validFrameNext = 1'b1;
                    w_shiftNext      = {w_exitBit, r_shift[6:1]};
                    w_bitCntNext     = r_bitCnt + 3'd1;

                    if (r_bitCnt == 3'd7) begin
                        // Byte complete: bits arrive LSB first, so the newest
                        // bit lands in the MSB position.
                        if (r_byteCnt < c_BYTE_CNT_W'(MAX_BYTES)) begin
                            w_dataNext    = {w_exitBit, r_shift};
                            w_newByteNext = 1'b1;
                            w_byteCntNext = r_byteCnt + c_BYTE_CNT_W'(1);
                        end else begin
                            w_overflowNext = 1'b1;
                        end
                    end
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state       <= S_HUNT;
            r_ones        <= 3'd0;
            r_lineBits    <= '0;
            r_lineValid   <= '0;
            r_shift       <= '0;
            r_bitCnt      <= 3'd0;
            r_byteCnt     <= '0;
            r_flagDetect  <= 1'b0;
            r_abortDetect <= 1'b0;
            r_newByte     <= 1'b0;
            r_data        <= 8'h00;
            r_validFrame  <= 1'b0;
            r_eof         <= 1'b0;
            r_frameError  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_ones        <= w_onesNext;
            r_lineBits    <= w_lineBitsNext;
            r_lineValid   <= w_lineValidNext;
            r_shift       <= w_shiftNext;
            r_bitCnt      <= w_bitCntNext;
            r_byteCnt     <= w_byteCntNext;
            r_flagDetect  <= w_flagDetectNext;
            r_abortDetect <= w_abortDetectNext;
            r_newByte     <= w_newByteNext;
            r_data        <= w_dataNext;
            r_validFrame  <= w_validFrameNext;
            r_eof         <= w_eofNext;
            r_frameError  <= w_frameErrorNext;
            r_overflow    <= w_overflowNext;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs (all straight from flops)
    //--------------------------------------------------------------------------
    assign Rx_FlagDetect  = r_flagDetect;
    assign Rx_AbortDetect = r_abortDetect;
    assign Rx_NewByte     = r_newByte;
    assign Rx_Data        = r_data;
    assign Rx_ValidFrame  = r_validFrame;
    assign Rx_EoF         = r_eof;
    assign Rx_FrameError  = r_frameError;
    assign Rx_Overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_bitproc.sv
`default_nettype none
//==============================================================================
// Module   : tb_hdlc_rx_bitproc
// Purpose  : Self-checking bench for hdlc_rx_bitproc. A frame-level model
//            turns each raw bit stream into the list of events the receiver
//            must report; a monitor matches the DUT's strobes against it.
// Revision : 1.0 - initial release
//==============================================================================
module tb_hdlc_rx_bitproc;

    localparam int MAX_BYTES = 2;
`ifdef HDLC_RX_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam int K_VF    = 0;
    localparam int K_BYTE  = 1;
    localparam int K_OVF   = 2;
    localparam int K_EOF   = 3;
    localparam int K_FLAG  = 4;
    localparam int K_ABORT = 5;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b0;
    logic       RxEN = 1'b0;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_ValidFrame;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_Overflow;

    ev_t expQ[$];
    bit  raw[$];
    bit  payload[$];
    int  mOnes;
    bit  mHunt;
    int  txOnes;
    bit  gapsOn;
    int  nCompared = 0;
    int  nMismatch = 0;

    hdlc_rx_bitproc #(.MAX_BYTES(MAX_BYTES)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx            (Rx),
        .RxEN          (RxEN),
        .Rx_FlagDetect (Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_NewByte    (Rx_NewByte),
        .Rx_Data       (Rx_Data),
        .Rx_ValidFrame (Rx_ValidFrame),
        .Rx_EoF        (Rx_EoF),
        .Rx_FrameError (Rx_FrameError),
        .Rx_Overflow   (Rx_Overflow)
    );

    always #5 Clk = ~Clk;

    //--------------------------------------------------------------------------
    // Reference model: frame-level view of the receiver
    //--------------------------------------------------------------------------
    task automatic pushEv(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    // A frame ends by flag (0), abort (1) or reset (2). Everything received
    // since the previous frame boundary except the last seven bits has been
    // delivered; those seven are the flag/abort prefix still in flight.
    task automatic frameEnd(input int kind);
        int         d;
        int         nb;
        logic [7:0] v;
        d = payload.size() - 7;
        if (d < 0) d = 0;
        if (!mHunt && d > 0) begin
            pushEv(K_VF, 8'h00);
            nb = d / 8;
            for (int k = 0; k < nb && k < MAX_BYTES; k++) begin
                for (int j = 0; j < 8; j++) v[j] = payload[8*k+j];
                pushEv(K_BYTE, v);
            end
            if (nb > MAX_BYTES) pushEv(K_OVF, 8'h00);
            if (kind == 0) pushEv(K_EOF, (d % 8 != 0) ? 8'h01 : 8'h00);
        end
        if (kind == 0) begin
            pushEv(K_FLAG, 8'h00);
            mHunt = 1'b0;
        end else if (kind == 1) begin
            if (!mHunt) pushEv(K_ABORT, 8'h00);
            mHunt = 1'b1;
        end else begin
            mHunt = 1'b1;
            mOnes = 0;
        end
        payload.delete();
    endtask

    task automatic modelBit(input bit b);
        if (b) begin
            if (ABORT_EN && mOnes == 6) begin
                mOnes = 7;
                frameEnd(1);
            end else begin
                payload.push_back(1'b1);
                if (mOnes < 7) mOnes++;
            end
        end else begin
            if (mOnes == 6) frameEnd(0);
            else if (mOnes != 5) payload.push_back(1'b0);
            mOnes = 0;
        end
    endtask

    //--------------------------------------------------------------------------
    // Transmit-side stimulus builders
    //--------------------------------------------------------------------------
    task automatic addFlag();
        raw.push_back(1'b0);
        repeat (6) raw.push_back(1'b1);
        raw.push_back(1'b0);
        txOnes = 0;
    endtask

    task automatic addDataBit(input bit b);
        raw.push_back(b);
        if (b) begin
            txOnes++;
            if (txOnes == 5) begin
                raw.push_back(1'b0);
                txOnes = 0;
            end
        end else begin
            txOnes = 0;
        end
    endtask

    task automatic addByte(input logic [7:0] v);
        for (int j = 0; j < 8; j++) addDataBit(v[j]);
    endtask

    task automatic addOnes(input int n);
        repeat (n) raw.push_back(1'b1);
        txOnes = 0;
    endtask

    //--------------------------------------------------------------------------
    // Drivers
    //--------------------------------------------------------------------------
    task automatic driveBit(input bit b);
        while (gapsOn && $urandom_range(0, 3) == 0) begin
            RxEN = 1'b0;
            Rx   = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
        end
        RxEN = 1'b1;
        Rx   = b;
        @(posedge Clk);
        #1;
        RxEN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            RxEN = 1'b0;
            Rx   = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic sendSegment();
        foreach (raw[i]) modelBit(raw[i]);
        foreach (raw[i]) driveBit(raw[i]);
        raw.delete();
        idle(4);
    endtask

    //--------------------------------------------------------------------------
    // Checking helpers
    //--------------------------------------------------------------------------
    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatch++;
            $display("FAIL %s: actual %02h required %02h", name, act, req);
        end
    endtask

    task automatic checkEv(input int kind, input logic [7:0] data, input string name);
        ev_t e;
        nCompared++;
        if (expQ.size() == 0) begin
            nMismatch++;
            $display("FAIL %s: DUT event data %02h, required no event", name, data);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.data !== data) begin
                nMismatch++;
                $display("FAIL %s: actual kind %0d data %02h, required kind %0d data %02h",
                         name, kind, data, e.kind, e.data);
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " FlagDetect"},  {7'd0, Rx_FlagDetect},  8'h00);
        checkVal({tag, " AbortDetect"}, {7'd0, Rx_AbortDetect}, 8'h00);
        checkVal({tag, " NewByte"},     {7'd0, Rx_NewByte},     8'h00);
        checkVal({tag, " Data"},        Rx_Data,                8'h00);
        checkVal({tag, " ValidFrame"},  {7'd0, Rx_ValidFrame},  8'h00);
        checkVal({tag, " EoF"},         {7'd0, Rx_EoF},         8'h00);
        checkVal({tag, " FrameError"},  {7'd0, Rx_FrameError},  8'h00);
        checkVal({tag, " Overflow"},    {7'd0, Rx_Overflow},    8'h00);
    endtask

    //--------------------------------------------------------------------------
    // Monitor
    //--------------------------------------------------------------------------
    initial begin
        bit prevVF;
        bit prevOvf;
        prevVF  = 1'b0;
        prevOvf = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                prevVF  = 1'b0;
                prevOvf = 1'b0;
            end else begin
                if (Rx_ValidFrame && !prevVF) checkEv(K_VF, 8'h00, "validframe_rise");
                if (Rx_NewByte) begin
                    checkEv(K_BYTE, Rx_Data, "newbyte");
                    checkVal("validframe_at_byte", {7'd0, Rx_ValidFrame}, 8'h01);
                end
                if (Rx_Overflow && !prevOvf) checkEv(K_OVF, 8'h00, "overflow_rise");
                if (Rx_EoF) begin
                    checkEv(K_EOF, {7'd0, Rx_FrameError}, "eof");
                    checkVal("validframe_at_eof", {7'd0, Rx_ValidFrame}, 8'h00);
                end else if (Rx_FrameError) begin
                    checkEv(K_EOF, 8'h81, "frameerror_without_eof");
                end
                if (Rx_FlagDetect) begin
                    checkEv(K_FLAG, 8'h00, "flag");
                    checkVal("overflow_at_flag", {7'd0, Rx_Overflow}, 8'h00);
                end
                if (Rx_AbortDetect) begin
                    checkEv(K_ABORT, 8'h00, "abort");
                    checkVal("validframe_at_abort", {7'd0, Rx_ValidFrame}, 8'h00);
                end
                prevVF  = Rx_ValidFrame;
                prevOvf = Rx_Overflow;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        int         nb;
        int         extra;
        logic [11:0] bits12;
        logic [7:0]  v;

        mOnes  = 0;
        mHunt  = 1'b1;
        txOnes = 0;
        gapsOn = 1'b0;

        #3 Rst = 1'b1;
        #1 checkResetOutputs("reset");
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;

        // Idle ones while hunting, then one clean frame
        addOnes(16); addFlag(); addByte(8'hA5); addFlag();
        sendSegment();

        // 0xFF needs a stuffed zero after its fifth one
        addFlag(); addByte(8'hFF); addFlag();
        sendSegment();

        // Seven ones after data: abort when enabled, plain data otherwise
        addFlag(); addByte(8'h12); addByte(8'h34); addOnes(7); addFlag();
        sendSegment();

        // 12 data bits: not byte aligned
        bits12 = 12'h5C3;
        addFlag();
        for (int j = 0; j < 12; j++) addDataBit(bits12[j]);
        addFlag();
        sendSegment();

        // Idle fill flags only
        addFlag(); addFlag(); addFlag();
        sendSegment();

        // Three bytes against a two-byte limit
        addFlag(); addByte(8'h11); addByte(8'h22); addByte(8'h33); addFlag();
        sendSegment();

        // Random frames with enable gaps
        gapsOn = 1'b1;
        for (int f = 0; f < 30; f++) begin
            addFlag();
            nb = $urandom_range(0, 4);
            for (int k = 0; k < nb; k++) begin
                case ($urandom_range(0, 3))
                    0:       v = 8'hFF;
                    1:       v = 8'h7E;
                    2:       v = 8'hF8;
                    default: v = 8'($urandom_range(0, 255));
                endcase
                addByte(v);
            end
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int j = 0; j < extra; j++) addDataBit(1'($urandom_range(0, 1)));
            if (ABORT_EN && $urandom_range(0, 4) == 0) addOnes(7);
        end
        addFlag();
        sendSegment();
        gapsOn = 1'b0;

        // Reset in the middle of a frame: delivered data stands, no EoF
        addFlag(); addByte(8'h5A); addByte(8'h3C);
        foreach (raw[i]) modelBit(raw[i]);
        frameEnd(2);
        foreach (raw[i]) driveBit(raw[i]);
        raw.delete();
        txOnes = 0;
        idle(3);
        Rst = 1'b1;
        #1 checkResetOutputs("midframe_reset");
        @(posedge Clk);
        #1 Rst = 1'b0;

        // Receiver must come back from HUNT cleanly
        addFlag(); addByte(8'h81); addFlag();
        sendSegment();

        idle(20);
        checkVal("pending_expected_events", 8'(expQ.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
